// File: rtl/dc_fu_dma_read_controller_pkg.sv
// Shared types and AXI constants for the fetching-unit DMA read path.
package dc_fu_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } dma_rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dc_fu_dma_read_controller_if.sv
// AXI4 read address channel plus the observed R-channel handshake signals.
interface dc_fu_dma_read_controller_if #(
  parameter int AXI_ARADDR_WIDTH = 32
);
  logic [AXI_ARADDR_WIDTH-1:0] araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;
  logic                        rvalid;
  logic                        rready;
  logic                        rlast;
  logic [1:0]                  rresp;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready, rvalid, rready, rlast, rresp
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready, rvalid, rready, rlast, rresp
  );
endinterface

// File: rtl/dc_fu_dma_address_generator.sv
// Splits one line into INCR bursts of at most 2**MAX_BURST_LEN beats and
// steps the burst address/length on every accepted AR.
module dc_fu_dma_address_generator #(
  parameter int FETCH_WORD_COUNT_WIDTH = 16,
  parameter int AXI_ARADDR_WIDTH       = 32,
  parameter int MAX_BURST_LEN          = 4,
  parameter int READ_DATA_SIZE         = 1
) (
  input  logic                                        clk,
  input  logic                                        nrst,
  input  logic                                        start_fetch,
  input  logic                                        next_addr,
  input  logic [AXI_ARADDR_WIDTH-1:0]                 base_addr,
  input  logic [FETCH_WORD_COUNT_WIDTH-1:0]           word_count,
  output logic [AXI_ARADDR_WIDTH-1:0]                 araddr,
  output logic [7:0]                                  arlen,
  output logic [FETCH_WORD_COUNT_WIDTH-MAX_BURST_LEN:0] trans_count
);
  localparam int CW    = FETCH_WORD_COUNT_WIDTH;
  localparam int AW    = AXI_ARADDR_WIDTH;
  localparam int TC_W  = FETCH_WORD_COUNT_WIDTH - MAX_BURST_LEN + 1;
  localparam int BEATS = 1 << MAX_BURST_LEN;
  localparam logic [AW-1:0] ADDR_STEP  = AW'(BEATS << READ_DATA_SIZE);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'((1 << READ_DATA_SIZE) - 1);
  localparam logic [CW-1:0] BEATS_W    = CW'(BEATS);

  logic [AW-1:0]   addr_q;
  logic [CW-1:0]   remaining_q;
  logic [TC_W-1:0] trans_q;
  logic [CW:0]     count_round;
  logic [CW-1:0]   burst_words;

  // Burst count is the word count rounded up to whole bursts.
  assign count_round = {1'b0, word_count} + (CW+1)'(BEATS - 1);
  assign burst_words = (remaining_q > BEATS_W) ? BEATS_W : remaining_q;

  assign araddr      = addr_q;
  assign arlen       = (burst_words == '0) ? 8'd0 : 8'(burst_words - CW'(1));
  assign trans_count = trans_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      trans_q     <= '0;
    end else if (start_fetch) begin
      addr_q      <= base_addr & ALIGN_MASK;
      remaining_q <= word_count;
      trans_q     <= TC_W'(count_round >> MAX_BURST_LEN);
    end else if (next_addr && (trans_q != '0)) begin
      addr_q      <= addr_q + ADDR_STEP;
      remaining_q <= (remaining_q > BEATS_W) ? (remaining_q - BEATS_W) : '0;
      trans_q     <= trans_q - TC_W'(1);
    end
  end
endmodule

// File: rtl/dc_fu_dma_read_controller.sv
// Line-fetch AR sequencer: issues one line's bursts, limits outstanding
// bursts by counting rlast, and flags line completion and read errors.
module dc_fu_dma_read_controller
  import dc_fu_dma_pkg::*;
#(
  parameter int FETCH_WORD_COUNT_WIDTH = 16,
  parameter int AXI_ARADDR_WIDTH       = 32,
  parameter int MAX_BURST_LEN          = 4,
  parameter int READ_DATA_SIZE         = 1,
  parameter int MAX_OUTSTANDING        = 4
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              en,
  input  logic                              line_req_valid,
  output logic                              line_req_ready,
  input  logic [AXI_ARADDR_WIDTH-1:0]       line_base_addr,
  input  logic [FETCH_WORD_COUNT_WIDTH-1:0] line_word_count,
  dc_fu_dma_read_controller_if.master       m_axi,
  output logic                              unaligned_read,
  output logic                              line_done,
  output logic                              busy,
  output logic                              rd_err
);
  localparam int TC_W  = FETCH_WORD_COUNT_WIDTH - MAX_BURST_LEN + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  dma_rd_state_t    state_q, state_d;
  logic [OUT_W-1:0] outstanding_q;
  logic [TC_W-1:0]  gen_trans_count;
  logic             accept, arvalid, ar_hs, r_last_beat, r_err_beat;

  assign accept      = en && line_req_valid && (state_q == ST_IDLE);
  assign arvalid     = en && (state_q == ST_ISSUE) && (gen_trans_count != '0) &&
                       (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign ar_hs       = arvalid && m_axi.arready;
  assign r_last_beat = en && m_axi.rvalid && m_axi.rready && m_axi.rlast;
  assign r_err_beat  = en && m_axi.rvalid && m_axi.rready && (m_axi.rresp != AXI_RESP_OKAY);

  dc_fu_dma_address_generator #(
    .FETCH_WORD_COUNT_WIDTH (FETCH_WORD_COUNT_WIDTH),
    .AXI_ARADDR_WIDTH       (AXI_ARADDR_WIDTH),
    .MAX_BURST_LEN          (MAX_BURST_LEN),
    .READ_DATA_SIZE         (READ_DATA_SIZE)
  ) u_addr_gen (
    .clk         (clk),
    .nrst        (nrst),
    .start_fetch (accept),
    .next_addr   (ar_hs),
    .base_addr   (line_base_addr),
    .word_count  (line_word_count),
    .araddr      (m_axi.araddr),
    .arlen       (m_axi.arlen),
    .trans_count (gen_trans_count)
  );

  assign m_axi.arvalid = arvalid;
  assign m_axi.arsize  = 3'(READ_DATA_SIZE);
  assign m_axi.arburst = AXI_BURST_INCR;
  assign line_req_ready = (state_q == ST_IDLE);
  assign line_done      = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (gen_trans_count == '0) state_d = ST_DRAIN;
      ST_DRAIN: if (outstanding_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else if (en) state_q <= state_d;
  end

  // An rlast with nothing outstanding is a stray beat and must not underflow.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      outstanding_q <= '0;
    end else if (ar_hs && !(r_last_beat && (outstanding_q != '0))) begin
      outstanding_q <= outstanding_q + OUT_W'(1);
    end else if (!ar_hs && r_last_beat && (outstanding_q != '0)) begin
      outstanding_q <= outstanding_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_err         <= 1'b0;
      unaligned_read <= 1'b0;
    end else begin
      if (accept) begin
        rd_err         <= 1'b0;
        unaligned_read <= line_base_addr[0];
      end else if (r_err_beat) begin
        rd_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dc_fu_dma_read_controller.sv
// Randomized bench: AXI slave responder plus a line-level reference model of
// the expected AR sequence, outstanding limit, completion and error flag.
module tb_dc_fu_dma_read_controller;
  localparam int MAX_OUT = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        line_req_valid;
  logic        line_req_ready;
  logic [31:0] line_base_addr;
  logic [15:0] line_word_count;
  logic        unaligned_read, line_done, busy, rd_err;

  dc_fu_dma_read_controller_if #(.AXI_ARADDR_WIDTH(32)) axi ();

  dc_fu_dma_read_controller #(
    .FETCH_WORD_COUNT_WIDTH (16),
    .AXI_ARADDR_WIDTH       (32),
    .MAX_BURST_LEN          (4),
    .READ_DATA_SIZE         (1),
    .MAX_OUTSTANDING        (MAX_OUT)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .en              (en),
    .line_req_valid  (line_req_valid),
    .line_req_ready  (line_req_ready),
    .line_base_addr  (line_base_addr),
    .line_word_count (line_word_count),
    .m_axi           (axi),
    .unaligned_read  (unaligned_read),
    .line_done       (line_done),
    .busy            (busy),
    .rd_err          (rd_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ar_pct = 100, r_pct = 100, r_allowed = 1000000, err_at = 0;
  bit r_en = 1'b1;
  ar_t got_ar[$];
  ar_t exp_ar[$];
  int  got_cyc[$];
  int  burst_q[$];
  int  beat_idx = 0, beat_cnt_line = 0, model_outs = 0;
  int  cap_viol = 0, rderr_mis = 0, arvalid_cnt = 0;
  int  done_cnt = 0, done_cyc = -1, last_rl_cyc = -1, acc_cnt = 0, acc_cyc = -1;
  bit  exp_rd_err = 1'b0, rd_err_at_done = 1'b0;

  // One clock of the AXI slave responder and the bench's own bookkeeping.
  task automatic tick();
    bit hs, beat, rl, acc;
    axi.arready = ($urandom_range(99) < ar_pct);
    axi.rready  = ($urandom_range(99) < 85);
    if (r_en && burst_q.size() > 0 && r_allowed > 0 && $urandom_range(99) < r_pct) begin
      axi.rvalid = 1'b1;
      axi.rlast  = (beat_idx == burst_q[0]);
      axi.rresp  = (beat_cnt_line + 1 == err_at) ? 2'b10 : 2'b00;
    end else begin
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rresp  = 2'b00;
    end
    #1;
    hs   = axi.arvalid && axi.arready;
    beat = en && axi.rvalid && axi.rready;
    rl   = beat && axi.rlast;
    acc  = en && line_req_valid && line_req_ready;
    if (axi.arvalid) arvalid_cnt++;
    if (axi.arvalid && model_outs >= MAX_OUT) cap_viol++;
    if (rd_err !== exp_rd_err) rderr_mis++;
    if (line_done) begin
      done_cnt++;
      done_cyc = cyc;
      rd_err_at_done = rd_err;
    end
    if (beat) begin
      beat_cnt_line++;
      if (axi.rlast) begin
        void'(burst_q.pop_front());
        beat_idx = 0;
        r_allowed--;
        last_rl_cyc = cyc;
      end else begin
        beat_idx++;
      end
    end
    if (hs && (!rl || model_outs == 0)) model_outs++;
    else if (!hs && rl && model_outs > 0) model_outs--;
    if (hs) begin
      got_ar.push_back({axi.araddr, axi.arlen});
      got_cyc.push_back(cyc);
      burst_q.push_back(int'(axi.arlen));
    end
    if (acc) begin
      acc_cnt++;
      acc_cyc = cyc;
      exp_rd_err = 1'b0;
      beat_cnt_line = 0;
    end else if (beat && axi.rresp != 2'b00) begin
      exp_rd_err = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic build_exp(input logic [31:0] base, input int count);
    ar_t e;
    int  words;
    exp_ar.delete();
    for (int i = 0; i * 16 < count; i++) begin
      words  = count - 16 * i;
      if (words > 16) words = 16;
      e.addr = (base & 32'hFFFF_FFFE) + 32'(32 * i);
      e.len  = 8'(words - 1);
      exp_ar.push_back(e);
    end
  endtask

  task automatic start_line(input logic [31:0] base, input int count, output bit ok);
    int a0 = acc_cnt;
    line_req_valid  = 1'b1;
    line_base_addr  = base;
    line_word_count = 16'(count);
    for (int i = 0; i < 50 && acc_cnt == a0; i++) tick();
    line_req_valid = 1'b0;
    ok = (acc_cnt != a0);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    checks++; if (line_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", line_req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", line_done); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err: got %b expected 0", rd_err); end
    checks++; if (unaligned_read !== 1'b0) begin errors++; $display("FAIL reset_unaligned: got %b expected 0", unaligned_read); end
    checks++; if (axi.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", axi.arvalid); end
    checks++; if (axi.araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", axi.araddr); end
    checks++; if (axi.arlen !== 8'h0) begin errors++; $display("FAIL reset_arlen: got %0d expected 0", axi.arlen); end
    checks++; if (axi.arsize !== 3'd1) begin errors++; $display("FAIL arsize: got %0d expected 1", axi.arsize); end
    checks++; if (axi.arburst !== 2'b01) begin errors++; $display("FAIL arburst: got %b expected 01", axi.arburst); end
  endtask

  task automatic test_enable();
    int a0 = acc_cnt;
    en = 1'b0;
    line_req_valid = 1'b1;
    line_base_addr = 32'h2000;
    line_word_count = 16'd16;
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_busy: got %b expected 0", busy); end
    checks++; if (axi.arvalid !== 1'b0) begin errors++; $display("FAIL enable_arvalid: got %b expected 0", axi.arvalid); end
    line_req_valid = 1'b0;
    en = 1'b1;
    checks++; if (acc_cnt != a0) begin errors++; $display("FAIL enable_accepts: got %0d expected %0d", acc_cnt, a0); end
  endtask

  task automatic test_line40();
    bit ok;
    int d0 = done_cnt;
    ar_pct = 100; r_pct = 100; r_en = 1'b1; err_at = 0;
    got_ar.delete(); got_cyc.delete();
    build_exp(32'h1000, 40);
    start_line(32'h1000, 40, ok);
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL l40_timeout: busy still 1 expected 0"); end
    checks++; if (got_ar.size() != exp_ar.size()) begin errors++; $display("FAIL l40_count: got %0d expected %0d", got_ar.size(), exp_ar.size()); end
    for (int i = 0; i < exp_ar.size() && i < got_ar.size(); i++) begin
      checks++; if (got_ar[i] !== exp_ar[i]) begin errors++; $display("FAIL l40_ar%0d: got %h/%0d expected %h/%0d", i, got_ar[i].addr, got_ar[i].len, exp_ar[i].addr, exp_ar[i].len); end
    end
    if (got_cyc.size() == 3) begin
      checks++; if (got_cyc[0] != acc_cyc + 1) begin errors++; $display("FAIL l40_first_ar_cycle: got %0d expected %0d", got_cyc[0], acc_cyc + 1); end
      checks++; if (got_cyc[2] != got_cyc[0] + 2) begin errors++; $display("FAIL l40_back_to_back: got %0d expected %0d", got_cyc[2], got_cyc[0] + 2); end
    end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL l40_done_pulses: got %0d expected %0d", done_cnt - d0, 1); end
    checks++; if (done_cyc != last_rl_cyc + 2) begin errors++; $display("FAIL l40_done_cycle: got %0d expected %0d", done_cyc, last_rl_cyc + 2); end
  endtask

  task automatic test_count32_unaligned();
    bit ok;
    got_ar.delete(); got_cyc.delete();
    build_exp(32'h1001, 32);
    start_line(32'h1001, 32, ok);
    checks++; if (unaligned_read !== 1'b1) begin errors++; $display("FAIL unaligned_flag: got %b expected 1", unaligned_read); end
    wait_idle(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL c32_timeout: busy still 1 expected 0"); end
    checks++; if (got_ar.size() != exp_ar.size()) begin errors++; $display("FAIL c32_count: got %0d expected %0d", got_ar.size(), exp_ar.size()); end
    for (int i = 0; i < exp_ar.size() && i < got_ar.size(); i++) begin
      checks++; if (got_ar[i] !== exp_ar[i]) begin errors++; $display("FAIL c32_ar%0d: got %h/%0d expected %h/%0d", i, got_ar[i].addr, got_ar[i].len, exp_ar[i].addr, exp_ar[i].len); end
    end
  endtask

  task automatic test_outstanding_cap();
    bit ok;
    got_ar.delete(); got_cyc.delete();
    ar_pct = 100; r_en = 1'b0; r_pct = 100;
    build_exp(32'h4000, 160);
    start_line(32'h4000, 160, ok);
    repeat (20) tick();
    checks++; if (got_ar.size() != MAX_OUT) begin errors++; $display("FAIL cap_initial: got %0d expected %0d", got_ar.size(), MAX_OUT); end
    checks++; if (axi.arvalid !== 1'b0) begin errors++; $display("FAIL cap_arvalid: got %b expected 0", axi.arvalid); end
    for (int k = 0; k < 2; k++) begin
      r_allowed = 1; r_en = 1'b1;
      for (int i = 0; i < 200 && r_allowed > 0; i++) tick();
      repeat (5) tick();
      checks++; if (got_ar.size() != MAX_OUT + 1 + k) begin errors++; $display("FAIL cap_release%0d: got %0d expected %0d", k, got_ar.size(), MAX_OUT + 1 + k); end
    end
    r_allowed = 1000000;
    wait_idle(4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL cap_timeout: busy still 1 expected 0"); end
    checks++; if (got_ar.size() != exp_ar.size()) begin errors++; $display("FAIL cap_count: got %0d expected %0d", got_ar.size(), exp_ar.size()); end
    for (int i = 0; i < exp_ar.size() && i < got_ar.size(); i++) begin
      checks++; if (got_ar[i] !== exp_ar[i]) begin errors++; $display("FAIL cap_ar%0d: got %h/%0d expected %h/%0d", i, got_ar[i].addr, got_ar[i].len, exp_ar[i].addr, exp_ar[i].len); end
    end
    checks++; if (cap_viol != 0) begin errors++; $display("FAIL cap_violations: got %0d expected 0", cap_viol); end
  endtask

  task automatic test_zero_count();
    bit ok;
    int d0 = done_cnt;
    int v0 = arvalid_cnt;
    start_line(32'h3000, 0, ok);
    repeat (3) tick();
    checks++; if (done_cyc != acc_cyc + 3) begin errors++; $display("FAIL zero_done_cycle: got %0d expected %0d", done_cyc, acc_cyc + 3); end
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt - d0); end
    checks++; if (line_req_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_n4: got %b expected 1", line_req_ready); end
    checks++; if (arvalid_cnt != v0) begin errors++; $display("FAIL zero_arvalid: got %0d expected %0d", arvalid_cnt - v0, 0); end
  endtask

  task automatic test_rd_err();
    bit ok;
    int d0 = done_cnt;
    r_en = 1'b1; r_pct = 100; err_at = 5;
    start_line(32'h5000, 40, ok);
    wait_idle(2000, ok);
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL err_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (rd_err_at_done !== 1'b1) begin errors++; $display("FAIL err_at_done: got %b expected 1", rd_err_at_done); end
    tick();
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", rd_err); end
    err_at = 0;
    start_line(32'h5100, 16, ok);
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", rd_err); end
    wait_idle(2000, ok);
    checks++; if (rderr_mis != 0) begin errors++; $display("FAIL err_model: got %0d mismatching cycles expected 0", rderr_mis); end
  endtask

  task automatic test_reset_mid_line();
    bit ok;
    int d0;
    r_en = 1'b0; ar_pct = 100;
    start_line(32'h6000, 32, ok);
    for (int i = 0; i < 50 && got_ar.size() < 2; i++) tick();
    repeat (3) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    nrst = 1'b0;
    #1;
    checks++; if (line_req_ready !== 1'b1 || busy !== 1'b0 || line_done !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: got ready=%b busy=%b done=%b expected 1 0 0", line_req_ready, busy, line_done); end
    checks++; if (axi.arvalid !== 1'b0 || axi.araddr !== 32'h0 || axi.arlen !== 8'h0) begin errors++; $display("FAIL mid_reset_ar: got v=%b a=%h l=%0d expected 0 0 0", axi.arvalid, axi.araddr, axi.arlen); end
    checks++; if (rd_err !== 1'b0 || unaligned_read !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got %b %b expected 0 0", rd_err, unaligned_read); end
    burst_q.delete(); model_outs = 0; beat_idx = 0; exp_rd_err = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    axi.rvalid = 1'b1; axi.rready = 1'b1; axi.rlast = 1'b1; axi.rresp = 2'b00;
    @(posedge clk); #1;
    axi.rvalid = 1'b0; axi.rlast = 1'b0;
    got_ar.delete(); got_cyc.delete();
    r_en = 1'b1; r_pct = 100;
    d0 = done_cnt;
    build_exp(32'h7000, 40);
    start_line(32'h7000, 40, ok);
    wait_idle(2000, ok);
    checks++; if (!ok || done_cnt != d0 + 1) begin errors++; $display("FAIL mid_next_line: got idle=%b done=%0d expected 1 1", ok, done_cnt - d0); end
    checks++; if (got_ar.size() != exp_ar.size()) begin errors++; $display("FAIL mid_count: got %0d expected %0d", got_ar.size(), exp_ar.size()); end
    for (int i = 0; i < exp_ar.size() && i < got_ar.size(); i++) begin
      checks++; if (got_ar[i] !== exp_ar[i]) begin errors++; $display("FAIL mid_ar%0d: got %h/%0d expected %h/%0d", i, got_ar[i].addr, got_ar[i].len, exp_ar[i].addr, exp_ar[i].len); end
    end
  endtask

  task automatic test_random_lines();
    bit ok;
    int d0, cnt;
    logic [31:0] base;
    for (int n = 0; n < 10; n++) begin
      base   = $urandom & 32'h0FFF_FFFF;
      cnt    = $urandom_range(0, 100);
      ar_pct = $urandom_range(30, 100);
      r_pct  = $urandom_range(30, 100);
      err_at = (cnt > 0 && $urandom_range(3) == 0) ? $urandom_range(1, cnt) : 0;
      got_ar.delete(); got_cyc.delete();
      build_exp(base, cnt);
      d0 = done_cnt;
      start_line(base, cnt, ok);
      checks++; if (unaligned_read !== base[0]) begin errors++; $display("FAIL rnd%0d_unaligned: got %b expected %b", n, unaligned_read, base[0]); end
      wait_idle(4000, ok);
      checks++; if (!ok || done_cnt != d0 + 1) begin errors++; $display("FAIL rnd%0d_done: got idle=%b pulses=%0d expected 1 1", n, ok, done_cnt - d0); end
      checks++; if (got_ar.size() != exp_ar.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", n, got_ar.size(), exp_ar.size()); end
      for (int i = 0; i < exp_ar.size() && i < got_ar.size(); i++) begin
        checks++; if (got_ar[i] !== exp_ar[i]) begin errors++; $display("FAIL rnd%0d_ar%0d: got %h/%0d expected %h/%0d", n, i, got_ar[i].addr, got_ar[i].len, exp_ar[i].addr, exp_ar[i].len); end
      end
    end
    checks++; if (cap_viol != 0) begin errors++; $display("FAIL rnd_cap: got %0d expected 0", cap_viol); end
    checks++; if (rderr_mis != 0) begin errors++; $display("FAIL rnd_rd_err: got %0d mismatching cycles expected 0", rderr_mis); end
  endtask

  initial begin
    nrst = 1'b0; en = 1'b1;
    line_req_valid = 1'b0; line_base_addr = '0; line_word_count = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rready = 1'b0;
    axi.rlast = 1'b0; axi.rresp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    test_reset();
    test_enable();
    test_line40();
    test_count32_unaligned();
    test_outstanding_cap();
    test_zero_count();
    test_rd_err();
    test_reset_mid_line();
    test_random_lines();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
